// File: rtl/vga_fb_ctrl_80x60.sv
// Access controller for the 80x60 VGA framebuffer: handshaked (x, y) pixel reads/writes
// plus a one-pixel-per-clock hardware fill engine over all 4800 visible pixels.
module vga_fb_ctrl_80x60 (
  input  logic        CLK_50MHz,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WR,
  input  logic [6:0]  X,
  input  logic [5:0]  Y,
  input  logic [7:0]  DIN,
  output logic        ACK,
  output logic        ERR,
  output logic [7:0]  RDATA,
  input  logic        FILL_START,
  input  logic [7:0]  FILL_COLOR,
  output logic        FILL_BUSY,
  output logic        FILL_DONE,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_WD,
  input  logic [7:0]  FB_RD
);

  localparam logic [6:0]  NUM_COLS  = 7'd80;
  localparam logic [5:0]  NUM_ROWS  = 6'd60;
  localparam logic [6:0]  LAST_X    = 7'd79;
  localparam logic [12:0] LAST_ADDR = {6'd59, 7'd79};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_FILL
  } state_t;

  state_t      state_reg, state_next;
  logic        fb_we_reg, fb_we_next;
  logic [12:0] fb_addr_reg, fb_addr_next;
  logic [7:0]  fb_wd_reg, fb_wd_next;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        pending_reg, pending_next;
  logic [7:0]  color_reg, color_next;
  logic        req_wr_reg, req_wr_next;
  logic        req_oor_reg, req_oor_next;

  logic        fill_accept;
  logic        req_oor;
  logic [5:0]  fill_y_inc;

  assign fill_accept = FILL_START & ~busy_reg;
  assign req_oor     = (X >= NUM_COLS) | (Y >= NUM_ROWS);
  assign fill_y_inc  = fb_addr_reg[12:7] + 6'd1;

  always_comb begin
    state_next   = state_reg;
    fb_we_next   = 1'b0;
    fb_addr_next = fb_addr_reg;
    fb_wd_next   = fb_wd_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    rdata_next   = rdata_reg;
    done_next    = 1'b0;
    busy_next    = busy_reg | fill_accept;
    pending_next = pending_reg | fill_accept;
    color_next   = fill_accept ? FILL_COLOR : color_reg;
    req_wr_next  = req_wr_reg;
    req_oor_next = req_oor_reg;

    case (state_reg)
      S_IDLE: begin
        // Fill beats REQ; a start accepted this very cycle launches immediately.
        if (pending_reg || fill_accept) begin
          state_next   = S_FILL;
          fb_we_next   = 1'b1;
          fb_addr_next = 13'd0;
          fb_wd_next   = color_next;
          pending_next = 1'b0;
        end else if (REQ) begin
          state_next   = S_ACCESS;
          req_wr_next  = WR;
          req_oor_next = req_oor;
          if (!req_oor) begin
            fb_we_next   = WR;
            fb_addr_next = {Y, X};
            fb_wd_next   = DIN;
          end
        end
      end
      S_ACCESS: begin
        // FB_RD still shows the pre-write contents during a write cycle.
        state_next = S_RESP;
        ack_next   = 1'b1;
        err_next   = req_oor_reg;
        rdata_next = req_oor_reg ? 8'd0 : FB_RD;
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      S_FILL: begin
        if (fb_addr_reg == LAST_ADDR) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else begin
          fb_we_next = 1'b1;
          if (fb_addr_reg[6:0] == LAST_X) begin
            fb_addr_next = {fill_y_inc, 7'd0};
          end else begin
            fb_addr_next = fb_addr_reg + 13'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!RST_N) begin
      state_reg   <= S_IDLE;
      fb_we_reg   <= 1'b0;
      fb_addr_reg <= 13'd0;
      fb_wd_reg   <= 8'd0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= 8'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      pending_reg <= 1'b0;
      color_reg   <= 8'd0;
      req_wr_reg  <= 1'b0;
      req_oor_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fb_we_reg   <= fb_we_next;
      fb_addr_reg <= fb_addr_next;
      fb_wd_reg   <= fb_wd_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      pending_reg <= pending_next;
      color_reg   <= color_next;
      req_wr_reg  <= req_wr_next;
      req_oor_reg <= req_oor_next;
    end
  end

  assign ACK       = ack_reg;
  assign ERR       = err_reg;
  assign RDATA     = rdata_reg;
  assign FILL_BUSY = busy_reg;
  assign FILL_DONE = done_reg;
  assign FB_WE     = fb_we_reg;
  assign FB_ADDR   = fb_addr_reg;
  assign FB_WD     = fb_wd_reg;

endmodule

// File: tb/tb_vga_fb_ctrl_80x60.sv
// Directed bench for vga_fb_ctrl_80x60 with an asynchronous-read framebuffer model.
module tb_vga_fb_ctrl_80x60;

  logic        CLK_50MHz = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ = 1'b0;
  logic        WR = 1'b0;
  logic [6:0]  X = 7'd0;
  logic [5:0]  Y = 6'd0;
  logic [7:0]  DIN = 8'd0;
  logic        ACK, ERR;
  logic [7:0]  RDATA;
  logic        FILL_START = 1'b0;
  logic [7:0]  FILL_COLOR = 8'd0;
  logic        FILL_BUSY, FILL_DONE;
  logic        FB_WE;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_WD;
  logic [7:0]  FB_RD;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:8191];
  logic        mem_clr = 1'b1;
  int          we_cnt = 0;
  int          badcol_cnt = 0;
  int          done_cnt = 0;
  logic [12:0] last_we_addr = 13'd0;

  always #10 CLK_50MHz = ~CLK_50MHz;

  vga_fb_ctrl_80x60 dut (
    .CLK_50MHz (CLK_50MHz),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .WR        (WR),
    .X         (X),
    .Y         (Y),
    .DIN       (DIN),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .FILL_START(FILL_START),
    .FILL_COLOR(FILL_COLOR),
    .FILL_BUSY (FILL_BUSY),
    .FILL_DONE (FILL_DONE),
    .FB_WE     (FB_WE),
    .FB_ADDR   (FB_ADDR),
    .FB_WD     (FB_WD),
    .FB_RD     (FB_RD)
  );

  // Framebuffer model: asynchronous read, write on the clock edge.
  assign FB_RD = mem[FB_ADDR];

  always @(posedge CLK_50MHz) begin
    if (mem_clr) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'd0;
    end else if (FB_WE) begin
      mem[FB_ADDR] <= FB_WD;
    end
    if (FB_WE) begin
      we_cnt <= we_cnt + 1;
      last_we_addr <= FB_ADDR;
      if (FB_ADDR[6:0] >= 7'd80) badcol_cnt <= badcol_cnt + 1;
    end
    if (FILL_DONE) done_cnt <= done_cnt + 1;
  end

  task automatic cyc();
    @(posedge CLK_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns in the ACK cycle; lat counts cycles from the REQ-sampling cycle.
  task automatic req_access(input logic wr, input logic [6:0] x, input logic [5:0] y,
                            input logic [7:0] din, output int lat);
    REQ = 1'b1; WR = wr; X = x; Y = y; DIN = din;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (ACK !== 1'b1 && lat < 20);
    REQ = 1'b0; WR = 1'b0;
    $display("req wr=%0d x=%0d y=%0d din=0x%0h -> lat=%0d ack=%0b err=%0b rdata=0x%0h",
             wr, x, y, din, lat, ACK, ERR, RDATA);
  endtask

  int lat, n, m, base_we, base_bad, base_done, acks_in_fill, odd_pix;

  initial begin
    // Reset
    repeat (3) cyc();
    chk("rst_ack", ACK, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_rdata", RDATA, 8'd0);
    chk("rst_busy", FILL_BUSY, 1'b0);
    chk("rst_done", FILL_DONE, 1'b0);
    chk("rst_we", FB_WE, 1'b0);
    chk("rst_addr", FB_ADDR, 13'd0);
    chk("rst_wd", FB_WD, 8'd0);
    RST_N = 1'b1;
    mem_clr = 1'b0;
    cyc();

    // Write (5,2) = 0xA5, then read it back
    REQ = 1'b1; WR = 1'b1; X = 7'd5; Y = 6'd2; DIN = 8'hA5;
    cyc();
    chk("wr_we_n1", FB_WE, 1'b1);
    chk("wr_addr_n1", FB_ADDR, 13'd261);
    chk("wr_wd_n1", FB_WD, 8'hA5);
    chk("wr_noack_n1", ACK, 1'b0);
    cyc();
    chk("wr_ack_n2", ACK, 1'b1);
    chk("wr_err_n2", ERR, 1'b0);
    chk("wr_rdata_prewrite", RDATA, 8'h00);
    REQ = 1'b0; WR = 1'b0;
    $display("write x=5 y=2 din=0xa5 -> ack=%0b err=%0b", ACK, ERR);
    cyc();
    chk("wr_ack_drop_n3", ACK, 1'b0);

    req_access(1'b0, 7'd5, 6'd2, 8'h00, lat);
    chk("rd_lat", lat, 2);
    chk("rd_data", RDATA, 8'hA5);
    chk("rd_err", ERR, 1'b0);
    cyc();

    // Out of range write at X=80
    base_we = we_cnt;
    REQ = 1'b1; WR = 1'b1; X = 7'd80; Y = 6'd0; DIN = 8'h77;
    cyc();
    chk("oorx_we_n1", FB_WE, 1'b0);
    chk("oorx_addr_hold", FB_ADDR, 13'd261);
    cyc();
    chk("oorx_ack", ACK, 1'b1);
    chk("oorx_err", ERR, 1'b1);
    chk("oorx_rdata", RDATA, 8'h00);
    REQ = 1'b0; WR = 1'b0;
    $display("write x=80 y=0 -> ack=%0b err=%0b rdata=0x%0h", ACK, ERR, RDATA);
    cyc();
    chk("oorx_err_drop", ERR, 1'b0);

    // Out of range write at Y=60
    req_access(1'b1, 7'd0, 6'd60, 8'h66, lat);
    chk("oory_lat", lat, 2);
    chk("oory_err", ERR, 1'b1);
    chk("oory_rdata", RDATA, 8'h00);
    cyc();
    chk("oor_no_writes", we_cnt - base_we, 0);

    // Full fill with 0x3C
    base_we = we_cnt; base_bad = badcol_cnt; base_done = done_cnt;
    FILL_START = 1'b1; FILL_COLOR = 8'h3C;
    cyc();
    FILL_START = 1'b0;
    chk("fill_busy_n1", FILL_BUSY, 1'b1);
    chk("fill_we_n1", FB_WE, 1'b1);
    chk("fill_addr_n1", FB_ADDR, 13'd0);
    chk("fill_wd_n1", FB_WD, 8'h3C);
    n = 1;
    while (FILL_DONE !== 1'b1 && n < 6000) begin
      cyc();
      n++;
    end
    $display("fill color=0x3c -> done at N+%0d", n);
    chk("fill_done_lat", n, 4801);
    chk("fill_busy_clear", FILL_BUSY, 1'b0);
    chk("fill_we_clear", FB_WE, 1'b0);
    chk("fill_we_count", we_cnt - base_we, 4800);
    chk("fill_bad_cols", badcol_cnt - base_bad, 0);
    chk("fill_last_addr", last_we_addr, 13'd7631);
    cyc();
    chk("fill_done_pulse", FILL_DONE, 1'b0);
    chk("fill_done_count", done_cnt - base_done, 1);

    req_access(1'b0, 7'd0, 6'd0, 8'h00, lat);
    chk("fill_rd_0_0", RDATA, 8'h3C);
    cyc();
    req_access(1'b0, 7'd79, 6'd59, 8'h00, lat);
    chk("fill_rd_79_59", RDATA, 8'h3C);
    cyc();
    req_access(1'b0, 7'd40, 6'd30, 8'h00, lat);
    chk("fill_rd_40_30", RDATA, 8'h3C);
    chk("fill_rd_lat", lat, 2);
    cyc();

    // FILL_START mid-fill is ignored
    base_done = done_cnt;
    FILL_START = 1'b1; FILL_COLOR = 8'h11;
    cyc();
    FILL_START = 1'b0;
    n = 1;
    repeat (50) begin cyc(); n++; end
    FILL_START = 1'b1; FILL_COLOR = 8'hFF;
    cyc(); n++;
    FILL_START = 1'b0;
    chk("busy_still_busy", FILL_BUSY, 1'b1);
    chk("busy_wd_kept", FB_WD, 8'h11);
    while (FILL_DONE !== 1'b1 && n < 6000) begin
      cyc();
      n++;
    end
    $display("fill color=0x11 with ignored restart -> done at N+%0d", n);
    chk("busy_done_lat", n, 4801);
    repeat (10) cyc();
    chk("busy_single_done", done_cnt - base_done, 1);
    chk("busy_not_restarted", FILL_BUSY, 1'b0);
    odd_pix = 0;
    for (int yy = 0; yy < 60; yy++)
      for (int xx = 0; xx < 80; xx++)
        if (mem[yy * 128 + xx] !== 8'h11) odd_pix++;
    chk("busy_buffer_colour", odd_pix, 0);

    // REQ and FILL_START together: fill first, ACK two cycles after FILL_DONE
    REQ = 1'b1; WR = 1'b0; X = 7'd1; Y = 6'd1; DIN = 8'h00;
    FILL_START = 1'b1; FILL_COLOR = 8'h22;
    cyc();
    FILL_START = 1'b0;
    chk("sim_busy_n1", FILL_BUSY, 1'b1);
    acks_in_fill = 0;
    n = 1;
    while (FILL_DONE !== 1'b1 && n < 6000) begin
      if (ACK === 1'b1) acks_in_fill++;
      cyc();
      n++;
    end
    chk("sim_done_lat", n, 4801);
    chk("sim_no_ack_in_fill", acks_in_fill, 0);
    m = 0;
    while (ACK !== 1'b1 && m < 20) begin
      cyc();
      m++;
    end
    REQ = 1'b0;
    $display("simultaneous req+fill -> done at N+%0d, ack %0d cycles later rdata=0x%0h", n, m, RDATA);
    chk("sim_ack_after_done", m, 2);
    chk("sim_rdata", RDATA, 8'h22);
    chk("sim_err", ERR, 1'b0);
    cyc();

    // Reset after 100 fill writes
    base_we = we_cnt; base_done = done_cnt;
    FILL_START = 1'b1; FILL_COLOR = 8'h44;
    cyc();
    FILL_START = 1'b0;
    repeat (99) cyc();
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    $display("reset after 100 fill writes -> we=%0b busy=%0b addr=%0d", FB_WE, FILL_BUSY, FB_ADDR);
    chk("mrst_we", FB_WE, 1'b0);
    chk("mrst_addr", FB_ADDR, 13'd0);
    chk("mrst_wd", FB_WD, 8'd0);
    chk("mrst_busy", FILL_BUSY, 1'b0);
    chk("mrst_done", FILL_DONE, 1'b0);
    chk("mrst_ack", ACK, 1'b0);
    chk("mrst_rdata", RDATA, 8'd0);
    chk("mrst_write_count", we_cnt - base_we, 100);
    repeat (4900) cyc();
    chk("mrst_no_done", done_cnt - base_done, 0);
    req_access(1'b0, 7'd19, 6'd1, 8'h00, lat);
    chk("mrst_rd_lat", lat, 2);
    chk("mrst_rd_written", RDATA, 8'h44);
    cyc();
    req_access(1'b0, 7'd20, 6'd1, 8'h00, lat);
    chk("mrst_rd_unwritten", RDATA, 8'h22);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_ctrl_80x60.md
# vga_fb_ctrl_80x60

Access controller for the 80x60 VGA framebuffer, between the CPU-side MMIO logic and the framebuffer's read/write port. It turns (x, y) pixel read/write requests into single-cycle framebuffer accesses with a REQ/ACK handshake, and flags out-of-range coordinates. It also runs a hardware fill engine that writes one colour to all 4800 visible pixels, one pixel per clock. The VGA scan-out read port is not touched by this block.

## Interface

Parameters:
- none; the geometry is fixed at 80x60 and the row pitch at 128.

Ports:
- CLK_50MHz  in  1  system clock; the only clock.
- RST_N  in  1  reset, synchronous, active-low.
- REQ  in  1  pixel access request; held high by the requester until ACK.
- WR  in  1  1 = write, 0 = read; sampled with REQ.
- X  in  7  pixel column, valid 0..79.
- Y  in  6  pixel row, valid 0..59.
- DIN  in  8  write pixel data.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse with ACK when the coordinate is out of range.
- RDATA  out  8  read data; valid while ACK is high and held until the next ACK.
- FILL_START  in  1  fill command pulse.
- FILL_COLOR  in  8  fill colour; sampled with FILL_START.
- FILL_BUSY  out  1  high while a fill is pending or running.
- FILL_DONE  out  1  one-cycle pulse when a fill completes.
- FB_WE  out  1  framebuffer write enable (registered).
- FB_ADDR  out  13  framebuffer address (registered), {Y, X} = Y*128 + X.
- FB_WD  out  8  framebuffer write data (registered).
- FB_RD  in  8  framebuffer asynchronous read data at FB_ADDR.

## Operation

- Address mapping:
  - FB_ADDR = {y[5:0], x[6:0]}.
  - The top visible address is {59, 79} = 7631.
  - Columns 80..127 are never written.
- States: IDLE, ACCESS, RESP, FILL.
- IDLE:
  - If a fill is pending, go to FILL.
  - Otherwise, if REQ = 1, latch WR, X, Y and DIN, then go to ACCESS.
  - Fill always beats REQ when both are present.
- ACCESS (in range):
  - Drive FB_ADDR and FB_WD.
  - FB_WE = WR.
  - Capture FB_RD into RDATA at the end of the cycle (on a write, RDATA = the pre-write value).
  - Go to RESP.
- ACCESS (X ≥ 80 or Y ≥ 60):
  - FB_WE = 0 and FB_ADDR is unchanged.
  - RDATA = 0 and the error is flagged.
  - Go to RESP.
- RESP:
  - ACK = 1, and ERR = 1 if the access was flagged.
  - REQ is ignored in this cycle.
  - Go to IDLE.
- Fill acceptance:
  - FILL_START is accepted in any state when FILL_BUSY = 0.
  - On acceptance, latch FILL_COLOR and set pending; FILL_BUSY rises on the next cycle.
  - FILL_START while FILL_BUSY = 1 is ignored, and the colour is not updated.
- FILL:
  - FB_WE = 1 and FB_WD = the latched colour.
  - x steps 0..79; at x = 79, x wraps to 0 and y increments, over y 0..59.
  - After the write to {59, 79}, go to IDLE, pulse FILL_DONE and clear FILL_BUSY in the same cycle.
  - REQ is stalled (no ACK) throughout the fill.
- FB_WE is 0 in IDLE and RESP. FB_ADDR and FB_WD hold their last values there.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Pending fill, fill counters and latched request are cleared.
  - A reset mid-fill aborts the fill with no FILL_DONE. Pixels already written stay written.

## Timing

- Pixel access with REQ sampled in cycle N:
  - Memory access in N+1.
  - ACK (with RDATA and ERR) in N+2.
  - Back in IDLE in N+3, when the next REQ can be sampled.
  - One access per 3 cycles at most.
- Fill accepted in IDLE at cycle N:
  - FILL_BUSY = 1 from N+1.
  - Writes run from N+1 (addr 0) through N+4800 (addr 7631).
  - FILL_DONE = 1 and FILL_BUSY = 0 in N+4801.
  - A held REQ is sampled in N+4801 and ACKed in N+4803.
- Fill accepted during ACCESS or RESP:
  - The in-flight access completes normally.
  - FILL starts in the cycle after IDLE is entered.
- The FILL_DONE cycle is IDLE: a new FILL_START in that cycle is accepted.

## Test plan

- Write then read:
  - Stimulus: REQ with WR=1, X=5, Y=2, DIN=0xA5.
  - Response: FB_WE=1 and FB_ADDR=261 in N+1, ACK in N+2. A following read of (5, 2) returns RDATA=0xA5 with ERR=0.
- Out of range:
  - Stimulus: write request to X=80, Y=0, and a separate request to X=0, Y=60.
  - Response: each gives ACK and ERR in N+2, FB_WE stays 0, RDATA=0.
- Full fill:
  - Stimulus: FILL_START with FILL_COLOR=0x3C.
  - Response: exactly 4800 FB_WE cycles, none with FB_ADDR[6:0] ≥ 80, last address 7631, FILL_DONE in N+4801. Afterwards, reads of (0, 0), (79, 59) and (40, 30) all return 0x3C.
- Simultaneous start:
  - Stimulus: REQ and FILL_START in the same IDLE cycle.
  - Response: fill runs first, REQ is held with no ACK, and ACK arrives 2 cycles after FILL_DONE.
- Busy fill:
  - Stimulus: FILL_START mid-fill with colour 0xFF.
  - Response: ignored, and the whole buffer keeps the original colour.
- Reset mid-fill:
  - Stimulus: RST_N=0 for 1 cycle after 100 fill writes.
  - Response: all outputs 0 next cycle, no FILL_DONE, and a subsequent REQ is served normally.
